// File: rtl/rmii_rx_framer.sv
// RMII receive framer: hunts preamble/SFD, assembles dibits into bytes, checks the CRC-32 FCS
// and reports length and errors with an end-of-frame strobe.
module rmii_rx_framer #(
  parameter int unsigned C_min_preamble = 4,
  parameter int unsigned C_max_len      = 1536
) (
  input  logic        clk,
  input  logic        resn,
  input  logic        rmii_crs_dv,
  input  logic [1:0]  rmii_rxd,
  output logic [7:0]  data,
  output logic        valid,
  output logic        sof,
  output logic        eof,
  output logic [10:0] len,
  output logic        crc_ok,
  output logic        err
);

  localparam logic [31:0] CrcPoly    = 32'hEDB8_8320;
  localparam logic [31:0] CrcInit    = 32'hFFFF_FFFF;
  localparam logic [31:0] CrcResidue = 32'hDEBB_20E3;
  localparam logic [10:0] MaxLen     = 11'(C_max_len);

  typedef enum logic [1:0] {StIdle, StPreamble, StData, StDrop} state_e;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
    end
    return c;
  endfunction

  // Input synchroniser stages
  logic       s1_dv_q, s2_dv_q;
  logic [1:0] s1_rxd_q, s2_rxd_q;

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      s1_dv_q  <= 1'b0;
      s1_rxd_q <= 2'b00;
      s2_dv_q  <= 1'b0;
      s2_rxd_q <= 2'b00;
    end else begin
      s1_dv_q  <= rmii_crs_dv;
      s1_rxd_q <= rmii_rxd;
      s2_dv_q  <= s1_dv_q;
      s2_rxd_q <= s1_rxd_q;
    end
  end

  logic carrier_end;
  assign carrier_end = !s2_dv_q && !s1_dv_q;

  // Framing stage
  state_e      state_q, state_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [1:0]  phase_q, phase_d;
  logic [5:0]  sr_q, sr_d;
  logic [7:0]  byte_q, byte_d;
  logic        byte_vld_q, byte_vld_d;
  logic        end_q, end_d;
  logic        end_err_q, end_err_d;

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    phase_d    = phase_q;
    sr_d       = sr_q;
    byte_d     = byte_q;
    byte_vld_d = 1'b0;
    end_d      = 1'b0;
    end_err_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Toggle tolerance only matters inside a frame; the idle dibit ahead of carrier is noise.
        if (s2_dv_q) begin
          if (s2_rxd_q == 2'b01) begin
            state_d   = StPreamble;
            pre_cnt_d = 4'd1;
          end else begin
            state_d = StDrop;
          end
        end
      end
      StPreamble: begin
        if (carrier_end) begin
          state_d = StIdle;
        end else if (s2_rxd_q == 2'b01) begin
          if (pre_cnt_q != 4'd15) pre_cnt_d = pre_cnt_q + 4'd1;
        end else if (s2_rxd_q == 2'b11 && 32'(pre_cnt_q) >= C_min_preamble) begin
          state_d = StData;
          phase_d = 2'd0;
          sr_d    = 6'd0;
        end else begin
          state_d = StDrop;
        end
      end
      StData: begin
        if (carrier_end) begin
          state_d   = StIdle;
          end_d     = 1'b1;
          end_err_d = (phase_q != 2'd0);
          phase_d   = 2'd0;
        end else begin
          phase_d = phase_q + 2'd1;
          unique case (phase_q)
            2'd0: sr_d[1:0] = s2_rxd_q;
            2'd1: sr_d[3:2] = s2_rxd_q;
            2'd2: sr_d[5:4] = s2_rxd_q;
            2'd3: begin
              byte_d     = {s2_rxd_q, sr_q};
              byte_vld_d = 1'b1;
            end
          endcase
        end
      end
      StDrop: begin
        if (carrier_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state_q    <= StIdle;
      pre_cnt_q  <= 4'd0;
      phase_q    <= 2'd0;
      sr_q       <= 6'd0;
      byte_q     <= 8'd0;
      byte_vld_q <= 1'b0;
      end_q      <= 1'b0;
      end_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      phase_q    <= phase_d;
      sr_q       <= sr_d;
      byte_q     <= byte_d;
      byte_vld_q <= byte_vld_d;
      end_q      <= end_d;
      end_err_q  <= end_err_d;
    end
  end

  // Output stage: byte strobes, CRC accumulation, end-of-frame status
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d, sof_q, sof_d, eof_q, eof_d;
  logic [10:0] len_q, len_d, cnt_q, cnt_d;
  logic        crc_ok_q, crc_ok_d, err_q, err_d;
  logic [31:0] crc_q, crc_d;
  logic        ovf_q, ovf_d, first_q, first_d;
  logic        frame_err;

  assign frame_err = end_err_q | ovf_q;

  always_comb begin
    data_d   = data_q;
    valid_d  = 1'b0;
    sof_d    = 1'b0;
    eof_d    = 1'b0;
    len_d    = len_q;
    crc_ok_d = crc_ok_q;
    err_d    = err_q;
    crc_d    = crc_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    first_d  = first_q;
    if (byte_vld_q) begin
      if (cnt_q < MaxLen) begin
        data_d  = byte_q;
        valid_d = 1'b1;
        sof_d   = first_q;
        first_d = 1'b0;
        cnt_d   = cnt_q + 11'd1;
        crc_d   = crc_byte(crc_q, byte_q);
      end else begin
        ovf_d = 1'b1;
      end
    end
    if (end_q) begin
      eof_d    = 1'b1;
      len_d    = cnt_q;
      err_d    = frame_err;
      crc_ok_d = (crc_q == CrcResidue) && !frame_err;
      crc_d    = CrcInit;
      cnt_d    = 11'd0;
      ovf_d    = 1'b0;
      first_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      data_q   <= 8'd0;
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      eof_q    <= 1'b0;
      len_q    <= 11'd0;
      crc_ok_q <= 1'b0;
      err_q    <= 1'b0;
      crc_q    <= CrcInit;
      cnt_q    <= 11'd0;
      ovf_q    <= 1'b0;
      first_q  <= 1'b1;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      sof_q    <= sof_d;
      eof_q    <= eof_d;
      len_q    <= len_d;
      crc_ok_q <= crc_ok_d;
      err_q    <= err_d;
      crc_q    <= crc_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      first_q  <= first_d;
    end
  end

  assign data   = data_q;
  assign valid  = valid_q;
  assign sof    = sof_q;
  assign eof    = eof_q;
  assign len    = len_q;
  assign crc_ok = crc_ok_q;
  assign err    = err_q;

endmodule

// File: tb/tb_rmii_rx_framer.sv
// Directed bench for rmii_rx_framer: good, corrupted, toggled, truncated, short-preamble,
// overlength, empty and reset-interrupted frames.
module tb_rmii_rx_framer;

  localparam int unsigned MaxLen = 64;

  logic        clk;
  logic        resn;
  logic        rmii_crs_dv;
  logic [1:0]  rmii_rxd;
  logic [7:0]  data;
  logic        valid, sof, eof;
  logic [10:0] len;
  logic        crc_ok, err;

  rmii_rx_framer #(
    .C_min_preamble(4),
    .C_max_len     (MaxLen)
  ) dut (
    .clk        (clk),
    .resn       (resn),
    .rmii_crs_dv(rmii_crs_dv),
    .rmii_rxd   (rmii_rxd),
    .data       (data),
    .valid      (valid),
    .sof        (sof),
    .eof        (eof),
    .len        (len),
    .crc_ok     (crc_ok),
    .err        (err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: owns all observation state
  int          cyc = 0;
  int          tot_valid = 0;
  int          tot_sof = 0;
  int          tot_eof = 0;
  int          both_cnt = 0;
  int          last_sof_idx = -1;
  int          eof_cyc = 0;
  logic [31:0] eof_len, eof_ok, eof_err;
  logic [7:0]  rx_mem [0:4095];
  int          vcyc_mem [0:4095];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid && eof) both_cnt <= both_cnt + 1;
    if (valid) begin
      rx_mem[tot_valid]   <= data;
      vcyc_mem[tot_valid] <= cyc;
      if (sof) begin
        last_sof_idx <= tot_valid;
        tot_sof      <= tot_sof + 1;
      end
      tot_valid <= tot_valid + 1;
    end
    if (eof) begin
      tot_eof <= tot_eof + 1;
      eof_cyc <= cyc;
      eof_len <= 32'(len);
      eof_ok  <= 32'(crc_ok);
      eof_err <= 32'(err);
    end
  end

  // Frame construction and driving
  logic [7:0] tx [$];
  int         drv_cyc;
  int         v_base, s_base, e_base;

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  task automatic build(input int n_payload, input bit good_fcs);
    logic [31:0] c;
    logic [31:0] fcs;
    logic [7:0]  b;
    tx.delete();
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n_payload; i++) begin
      b = 8'h10 + 8'(i);
      tx.push_back(b);
      c = crc_upd(c, b);
    end
    fcs = good_fcs ? ~c : 32'h0;
    for (int i = 0; i < 4; i++) tx.push_back(fcs[8*i +: 8]);
  endtask

  task automatic drive(input logic [1:0] d, input logic dv);
    @(negedge clk);
    rmii_crs_dv = dv;
    rmii_rxd    = d;
  endtask

  task automatic mark();
    @(negedge clk);
    v_base = tot_valid;
    s_base = tot_sof;
    e_base = tot_eof;
  endtask

  // n_pre 01-dibits, SFD, then n_dib data dibits; rst_k >= 0 pulses resn mid-frame
  task automatic send(input int n_pre, input int n_dib, input bit toggle, input int rst_k);
    logic [7:0] b;
    logic [1:0] d;
    logic       dv;
    for (int i = 0; i < n_pre; i++) drive(2'b01, 1'b1);
    drive(2'b11, 1'b1);
    for (int k = 0; k < n_dib; k++) begin
      b  = tx[k / 4];
      d  = 2'(b >> (2 * (k % 4)));
      dv = !(toggle && (k % 8) == 5 && k < n_dib - 4);
      drive(d, dv);
      if (k == 3) drv_cyc = cyc;
      if (k == rst_k) begin
        #3 resn = 1'b0;
        #1 check("reset_mid_outputs", {8'h0, data, len, valid, sof, eof, crc_ok, err}, 32'h0);
        v_base = tot_valid;
        s_base = tot_sof;
      end
      if (rst_k >= 0 && k == rst_k + 3) resn = 1'b1;
    end
    for (int i = 0; i < 12; i++) drive(2'b00, 1'b0);
  endtask

  task automatic check_frame(input string tag, input int n_valid, input int n_eof,
                             input int exp_len, input int exp_ok, input int exp_err);
    check({tag, ".nvalid"}, 32'(tot_valid - v_base), 32'(n_valid));
    check({tag, ".neof"}, 32'(tot_eof - e_base), 32'(n_eof));
    if (n_eof == 1) begin
      check({tag, ".len"}, eof_len, 32'(exp_len));
      check({tag, ".crc_ok"}, eof_ok, 32'(exp_ok));
      check({tag, ".err"}, eof_err, 32'(exp_err));
    end
  endtask

  task automatic check_bytes(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) if (rx_mem[v_base + i] !== tx[i]) bad++;
    check({tag, ".bytes"}, 32'(bad), 32'h0);
    check({tag, ".nsof"}, 32'(tot_sof - s_base), 32'd1);
    check({tag, ".sof_pos"}, 32'(last_sof_idx), 32'(v_base));
  endtask

  initial begin
    resn        = 1'b0;
    rmii_crs_dv = 1'b0;
    rmii_rxd    = 2'b00;
    repeat (3) @(negedge clk);
    check("reset_outputs", {8'h0, data, len, valid, sof, eof, crc_ok, err}, 32'h0);
    drive(2'b01, 1'b1);
    drive(2'b01, 1'b1);
    check("reset_ignores_input", {8'h0, data, len, valid, sof, eof, crc_ok, err}, 32'h0);
    rmii_crs_dv = 1'b0;
    rmii_rxd    = 2'b00;
    @(negedge clk);
    resn = 1'b1;
    repeat (4) @(negedge clk);

    // Good 64-byte frame, exactly at the length limit
    build(60, 1'b1);
    mark();
    send(31, 256, 1'b0, -1);
    check_frame("good", 64, 1, 64, 1, 0);
    check_bytes("good", 64);
    check("good.latency", 32'(vcyc_mem[v_base] - drv_cyc), 32'd4);
    check("good.eof_gap", 32'(eof_cyc - vcyc_mem[tot_valid - 1]), 32'd1);
    check("good.data_hold", 32'(data), 32'(tx[63]));
    check("good.len_hold", 32'(len), 32'd64);

    // One flipped payload bit
    build(60, 1'b1);
    tx[5] = tx[5] ^ 8'h08;
    mark();
    send(31, 256, 1'b0, -1);
    check_frame("bitflip", 64, 1, 64, 0, 0);

    // CRS_DV toggling inside data
    build(60, 1'b1);
    mark();
    send(31, 256, 1'b1, -1);
    check_frame("toggle", 64, 1, 64, 1, 0);
    check_bytes("toggle", 64);

    // Carrier lost two dibits into byte 10
    mark();
    send(31, 38, 1'b0, -1);
    check_frame("trunc", 9, 1, 9, 0, 1);

    // Short preamble is dropped, next frame is fine
    mark();
    send(2, 256, 1'b0, -1);
    check_frame("shortpre", 0, 0, 0, 0, 0);
    mark();
    send(31, 256, 1'b0, -1);
    check_frame("after_short", 64, 1, 64, 1, 0);

    // Empty frame: SFD then carrier end
    mark();
    send(31, 0, 1'b0, -1);
    check_frame("empty", 0, 1, 0, 0, 0);

    // Overlength: 66 bytes against a 64-byte limit
    build(62, 1'b1);
    mark();
    send(31, 264, 1'b0, -1);
    check_frame("overlen", 64, 1, 64, 0, 1);

    // Reset pulse during byte 20, zero FCS keeps the tail free of preamble patterns
    build(60, 1'b0);
    mark();
    send(31, 256, 1'b0, 77);
    check_frame("reset_mid", 0, 0, 0, 0, 0);
    build(60, 1'b1);
    mark();
    send(31, 256, 1'b0, -1);
    check_frame("after_reset", 64, 1, 64, 1, 0);
    check_bytes("after_reset", 64);

    check("valid_eof_overlap", 32'(both_cnt), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rmii_rx_framer.md
RMII_RX_FRAMER -- requirements
Module: rmii_rx_framer

Interface
REQ-001 SHALL have parameter C_min_preamble, default 4: minimum count of consecutive 2'b01 dibits required before the SFD.
REQ-002 SHALL have parameter C_max_len, default 1536: maximum number of bytes accepted per frame.
REQ-003 SHALL have port clk, input, 1 bit: 50 MHz RMII reference clock; all logic is on its rising edge.
REQ-004 SHALL have port resn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port rmii_crs_dv, input, 1 bit: RMII carrier sense / data valid.
REQ-006 SHALL have port rmii_rxd, input, 2 bits: RMII receive dibit, {rx1,rx0}.
REQ-007 SHALL have port data, output, 8 bits: received byte.
REQ-008 SHALL have port valid, output, 1 bit: one-cycle strobe qualifying data.
REQ-009 SHALL have port sof, output, 1 bit: high together with valid on the first byte after the SFD.
REQ-010 SHALL have port eof, output, 1 bit: one-cycle end-of-frame strobe.
REQ-011 SHALL have port len, output, 11 bits: byte count of the frame, including FCS; qualified by eof.
REQ-012 SHALL have port crc_ok, output, 1 bit: FCS check passed; qualified by eof.
REQ-013 SHALL have port err, output, 1 bit: alignment or overlength error; qualified by eof.

Function
REQ-014 SHALL register rmii_crs_dv and rmii_rxd into stage s1, then copy s1 into stage s2 on the next clock.
REQ-015 SHALL accept the dibit in s2 when s2.crs_dv=1, or when s2.crs_dv=0 and s1.crs_dv=1 (RMII CRS_DV toggle tolerance).
REQ-016 SHALL declare carrier end when both s2.crs_dv=0 and s1.crs_dv=0.
REQ-017 SHALL implement the states IDLE, PREAMBLE, DATA and DROP.
REQ-018 In IDLE, an accepted dibit 01 SHALL move the block to PREAMBLE with the preamble count set to 1; any other accepted dibit SHALL move it to DROP.
REQ-019 In PREAMBLE:
- an accepted 01 SHALL increment the preamble count, saturating at 15;
- an accepted 11 with count >= C_min_preamble SHALL move the block to DATA (SFD found);
- an accepted 11 with count < C_min_preamble, or any other dibit, SHALL move it to DROP;
- carrier end SHALL move it to IDLE.
REQ-020 In DROP, the block SHALL ignore all dibits until carrier end, then return to IDLE, with no eof.
REQ-021 In DATA, accepted dibits SHALL be assembled LSB-first: dibit k of a byte goes to bits [2k+1:2k], for k = 0..3.
REQ-022 After the 4th accepted dibit of a byte, the block SHALL present data with valid=1 for exactly one cycle, on the clock after that dibit was in s2 (3 clocks after the edge that sampled it at the pins).
REQ-023 sof SHALL be 1 only with the first valid of a frame.
REQ-024 SHALL compute the IEEE 802.3 CRC-32 (reflected polynomial 0xEDB88320, init 0xFFFFFFFF) over every emitted byte, FCS included.
REQ-025 On carrier end in DATA, the block SHALL assert eof for one cycle, one clock after the last valid (or in the cycle after carrier end if no byte is pending), then return to IDLE.
REQ-026 At eof:
- len SHALL equal the number of bytes emitted;
- crc_ok SHALL be 1 iff the CRC register equals the residue 0xDEBB20E3 (pre-complement) and err=0.
REQ-027 err SHALL be 1 at eof if the dibit phase is nonzero at carrier end; the partial byte is discarded.
REQ-028 err SHALL be 1 at eof if more than C_max_len bytes arrived; bytes beyond C_max_len produce no valid, and len saturates at C_max_len.
REQ-029 A frame ending with zero bytes (SFD followed by carrier end) SHALL give eof=1, len=0, crc_ok=0, err=0.
REQ-030 data, len, crc_ok and err SHALL hold their values between strobes.
REQ-031 valid and eof SHALL never be 1 in the same cycle.

Reset
REQ-032 While resn=0:
- state SHALL be IDLE;
- s1 and s2 SHALL be 0;
- data, len, valid, sof, eof, crc_ok and err SHALL be 0;
- the CRC register SHALL be 0xFFFFFFFF.
REQ-033 Reset asserted mid-frame SHALL discard the frame with no eof; after release, the block SHALL resynchronise on the next preamble only.

Verification
REQ-034 7x 0x55 + 0xD5 + 60-byte payload + correct FCS -> 64 valid strobes, sof on the first, eof with len=64, crc_ok=1, err=0.
REQ-035 Same frame with one payload bit flipped -> 64 bytes emitted, eof with crc_ok=0, err=0.
REQ-036 Same frame with single-cycle CRS_DV low pulses inside the data -> output identical to REQ-034.
REQ-037 Carrier dropped 2 dibits into byte 10 -> 9 valid strobes, eof with len=9, err=1, crc_ok=0.
REQ-038 Preamble of only 2 dibits of 01 before the SFD -> no valid and no eof; the next well-formed frame is received correctly.
REQ-039 resn pulsed low during byte 20 -> all outputs 0 immediately; the following frame is received correctly.
